// File: rtl/inv_sub_bytes_seq.sv
// Iterative AES InvSubBytes: LANES bytes/cycle through LANES shared inverse S-boxes (optional INV_SUB_BYTES_FLUSH_EN).
// Latency: 16/LANES RUN cycles; out_valid is high after 16/LANES+1 edges, counting the capture edge.
// Backpressure: in_ready=0 in RUN, in_ready=out_ready in DONE; ou held while out_ready=0.
module inv_sub_bytes_seq #(
    parameter int LANES = 4
) (
    input  logic         clk,
    input  logic         rst,
`ifdef INV_SUB_BYTES_FLUSH_EN
    input  logic         flush,
`endif
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] in,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] ou,
    output logic         busy
);

    generate
        if (!(LANES == 1 || LANES == 2 || LANES == 4 || LANES == 8 || LANES == 16)) begin : g_lanes_chk
            $error("inv_sub_bytes_seq: LANES must be 1, 2, 4, 8 or 16");
        end
    endgenerate

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    localparam logic [4:0] LANES_W  = 5'(LANES);
    localparam logic [4:0] LAST_CNT = 5'(16 - LANES);

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] m);
        logic [7:0] p;
        logic [7:0] x;
        p = '0;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (m[i]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    // a^254 == a^-1 in GF(2^8); zero naturally maps to zero.
    function automatic logic [7:0] gf_inv(input logic [7:0] a);
        logic [7:0] sq;
        logic [7:0] r;
        sq = a;
        r  = 8'h01;
        for (int i = 1; i < 8; i++) begin
            sq = gf_mul(sq, sq);
            r  = gf_mul(r, sq);
        end
        return r;
    endfunction

    function automatic logic [7:0] inv_sbox(input logic [7:0] s);
        logic [7:0] t;
        logic [7:0] d;
        d = 8'h05;
        for (int i = 0; i < 8; i++)
            t[i] = s[(i + 2) % 8] ^ s[(i + 5) % 8] ^ s[(i + 7) % 8] ^ d[i];
        return gf_inv(t);
    endfunction

    logic [1:0]   state;
    logic [4:0]   cnt;
    logic [127:0] work;
    logic [127:0] work_nxt;
    logic [7:0]   byt [16];

    // Only the LANES bytes selected by cnt pass through the shared S-boxes each cycle.
    always_comb begin
        for (int k = 0; k < 16; k++)
            byt[k] = work[127 - 8*k -: 8];
        for (int l = 0; l < LANES; l++)
            byt[cnt[3:0] + 4'(l)] = inv_sbox(byt[cnt[3:0] + 4'(l)]);
        work_nxt = '0;
        for (int k = 0; k < 16; k++)
            work_nxt[127 - 8*k -: 8] = byt[k];
    end

    assign in_ready  = (state == IDLE) || ((state == DONE) && out_ready);
    assign out_valid = (state == DONE);
    assign busy      = (state != IDLE);
    assign ou        = work;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= '0;
            work  <= '0;
        end
`ifdef INV_SUB_BYTES_FLUSH_EN
        else if (flush) begin
            state <= IDLE;
            cnt   <= '0;
        end
`endif
        else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        work  <= in;
                        cnt   <= '0;
                        state <= RUN;
                    end
                end
                RUN: begin
                    work <= work_nxt;
                    cnt  <= cnt + LANES_W;
                    if (cnt == LAST_CNT) state <= DONE;
                end
                DONE: begin
                    if (out_ready) begin
                        if (in_valid) begin
                            work  <= in;
                            cnt   <= '0;
                            state <= RUN;
                        end else begin
                            state <= IDLE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_inv_sub_bytes_seq.sv
// Bench for inv_sub_bytes_seq: LANES=4 main instance plus LANES=1/2/16 sweep instances,
// checked against an inverse S-box table derived by inverting the forward AES S-box.
module tb_inv_sub_bytes_seq;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst;
    logic         iv, ird, ov, ordy, bsy;
    logic [127:0] din, dout;
`ifdef INV_SUB_BYTES_FLUSH_EN
    logic         fl;
`endif

    logic         sv;
    logic [127:0] sin;
    logic [2:0]   s_ird, s_ov, s_bsy;
    logic [127:0] s_dout [3];

    inv_sub_bytes_seq #(.LANES(4)) dut (
        .clk(clk), .rst(rst),
`ifdef INV_SUB_BYTES_FLUSH_EN
        .flush(fl),
`endif
        .in_valid(iv), .in_ready(ird), .in(din),
        .out_valid(ov), .out_ready(ordy), .ou(dout), .busy(bsy)
    );

    inv_sub_bytes_seq #(.LANES(1)) u_l1 (
        .clk(clk), .rst(rst),
`ifdef INV_SUB_BYTES_FLUSH_EN
        .flush(1'b0),
`endif
        .in_valid(sv), .in_ready(s_ird[0]), .in(sin),
        .out_valid(s_ov[0]), .out_ready(1'b1), .ou(s_dout[0]), .busy(s_bsy[0])
    );

    inv_sub_bytes_seq #(.LANES(2)) u_l2 (
        .clk(clk), .rst(rst),
`ifdef INV_SUB_BYTES_FLUSH_EN
        .flush(1'b0),
`endif
        .in_valid(sv), .in_ready(s_ird[1]), .in(sin),
        .out_valid(s_ov[1]), .out_ready(1'b1), .ou(s_dout[1]), .busy(s_bsy[1])
    );

    inv_sub_bytes_seq #(.LANES(16)) u_l16 (
        .clk(clk), .rst(rst),
`ifdef INV_SUB_BYTES_FLUSH_EN
        .flush(1'b0),
`endif
        .in_valid(sv), .in_ready(s_ird[2]), .in(sin),
        .out_valid(s_ov[2]), .out_ready(1'b1), .ou(s_dout[2]), .busy(s_bsy[2])
    );

    int         tests = 0;
    int         fails = 0;
    logic [7:0] inv_tab [256];

    // Carry-less product followed by long division by x^8+x^4+x^3+x+1.
    function automatic logic [7:0] tb_mul(input logic [7:0] a, input logic [7:0] b);
        logic [15:0] p;
        p = '0;
        for (int i = 0; i < 8; i++)
            if (b[i]) p = p ^ (16'(a) << i);
        for (int i = 14; i >= 8; i--)
            if (p[i]) p = p ^ (16'h011b << (i - 8));
        return p[7:0];
    endfunction

    function automatic logic [7:0] rotl(input logic [7:0] x, input int n);
        return (x << n) | (x >> (8 - n));
    endfunction

    task automatic build_table();
        logic [7:0] inv, s;
        for (int x = 0; x < 256; x++) begin
            inv = 8'h00;
            if (x != 0)
                for (int y = 1; y < 256; y++)
                    if (tb_mul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            s = inv ^ rotl(inv, 1) ^ rotl(inv, 2) ^ rotl(inv, 3) ^ rotl(inv, 4) ^ 8'h63;
            inv_tab[s] = 8'(x);
        end
    endtask

    function automatic logic [127:0] ref_isb(input logic [127:0] s);
        logic [127:0] r;
        for (int k = 0; k < 16; k++)
            r[127 - 8*k -: 8] = inv_tab[s[127 - 8*k -: 8]];
        return r;
    endfunction

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [127:0] rnd128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // Latency counts edges from the capture edge (inclusive) to out_valid high.
    task automatic run_block(input logic [127:0] d, input int lat, input string tag);
        int n;
        chk({tag, " in_ready_idle"}, ird, 1);
        iv = 1'b1; din = d;
        tick();
        iv = 1'b0; din = rnd128();
        chk({tag, " busy_run"}, bsy, 1);
        chk({tag, " in_ready_run"}, ird, 0);
        n = 1;
        while (!ov && n < 40) begin
            tick();
            n++;
        end
        chk({tag, " latency"}, n, lat);
        chk({tag, " data"}, dout, ref_isb(d));
        if (ordy) begin
            tick();
            chk({tag, " back_idle"}, ov, 0);
        end
    endtask

    localparam logic [127:0] APPB_IN  = 128'he9098972cb31075f3d327d94af2e2cb5;
    localparam logic [127:0] APPB_OUT = 128'heb40f21e592e38848ba113e71bc342d2;

    initial begin
        logic [127:0] blk_a, blk_b, v;
        int n, ov_cnt;
        int lat [3];
        logic [127:0] sout [3];

        rst = 1'b1; iv = 1'b0; ordy = 1'b1; din = '0; sv = 1'b0; sin = '0;
`ifdef INV_SUB_BYTES_FLUSH_EN
        fl = 1'b0;
`endif
        build_table();
        #1;
        chk("reset out_valid", ov, 0);
        chk("reset busy", bsy, 0);
        chk("reset in_ready", ird, 1);
        chk("reset ou", dout, 0);
        repeat (2) @(posedge clk);
        @(negedge clk) rst = 1'b0;
        tick();

        // All-zero state: every byte becomes 0x52.
        run_block(128'h0, 5, "zero");
        chk("zero const", dout, {16{8'h52}});

        v = 128'h0001637C_FF090000_00000000_00000000;
        run_block(v, 5, "vec3");
        chk("vec3 const", dout, 128'h52090001_7D405252_52525252_52525252);

        for (int i = 0; i < 6; i++) run_block(rnd128(), 5, $sformatf("rand%0d", i));

        // Asynchronous reset in the middle of RUN.
        iv = 1'b1; din = rnd128();
        tick();
        iv = 1'b0;
        tick();
        rst = 1'b1;
        #1;
        chk("midrun rst out_valid", ov, 0);
        chk("midrun rst busy", bsy, 0);
        chk("midrun rst in_ready", ird, 1);
        chk("midrun rst ou", dout, 0);
        @(negedge clk) rst = 1'b0;
        ov_cnt = 0;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (ov) ov_cnt++;
        end
        chk("midrun rst no emit", ov_cnt, 0);

        // Backpressure in DONE, then same-edge emit and capture.
        ordy = 1'b0;
        blk_a = rnd128();
        blk_b = rnd128();
        run_block(blk_a, 5, "bp_a");
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("bp hold valid", ov, 1);
            chk("bp hold data", dout, ref_isb(blk_a));
            chk("bp in_ready", ird, 0);
        end
        ordy = 1'b1; iv = 1'b1; din = blk_b;
        #1;
        chk("bp in_ready follows out_ready", ird, 1);
        tick();
        iv = 1'b0; din = rnd128();
        chk("bp busy stays", bsy, 1);
        chk("bp valid drops", ov, 0);
        n = 1;
        while (!ov && n < 40) begin
            tick();
            n++;
        end
        chk("bp_b latency", n, 5);
        chk("bp_b data", dout, ref_isb(blk_b));
        tick();

        // LANES sweep on the FIPS-197 App.B final-round state.
        chk("sweep in_ready", s_ird, 3'b111);
        sv = 1'b1; sin = APPB_IN;
        tick();
        sv = 1'b0; sin = rnd128();
        for (int i = 0; i < 3; i++) begin
            lat[i] = 0;
            sout[i] = '0;
        end
        n = 1;
        while (n < 30) begin
            tick();
            n++;
            for (int i = 0; i < 3; i++)
                if (s_ov[i] && lat[i] == 0) begin
                    lat[i] = n;
                    sout[i] = s_dout[i];
                end
        end
        chk("sweep L1 latency", lat[0], 17);
        chk("sweep L2 latency", lat[1], 9);
        chk("sweep L16 latency", lat[2], 2);
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("sweep data %0d const", i), sout[i], APPB_OUT);
            chk($sformatf("sweep data %0d model", i), sout[i], ref_isb(APPB_IN));
        end
        chk("sweep idle", s_bsy, 3'b000);

`ifdef INV_SUB_BYTES_FLUSH_EN
        // Flush during the second RUN cycle.
        iv = 1'b1; din = rnd128();
        tick();
        iv = 1'b0;
        tick();
        fl = 1'b1;
        tick();
        fl = 1'b0;
        chk("flush run busy", bsy, 0);
        chk("flush run in_ready", ird, 1);
        ov_cnt = 0;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (ov) ov_cnt++;
        end
        chk("flush run no emit", ov_cnt, 0);

        // Flush beats a simultaneous capture in DONE.
        ordy = 1'b0;
        run_block(rnd128(), 5, "flush_done");
        ordy = 1'b1; iv = 1'b1; din = rnd128(); fl = 1'b1;
        tick();
        fl = 1'b0; iv = 1'b0;
        chk("flush done valid", ov, 0);
        chk("flush done no capture", bsy, 0);
        tick();
        chk("flush done still idle", bsy, 0);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
